// File: rtl/wrr_egress_arbiter_if.sv
// Handshake bundle between the ingress sources, one egress arbiter and its egress sink.
// The master modport is the arbiter side; the slave modport is the surrounding switch fabric.
interface wrr_egress_arbiter_if #(
  parameter int N_PORTS   = 4,
  parameter int IDX_WIDTH = $clog2(N_PORTS)
);
  logic [N_PORTS-1:0]           ingress_valid;
  logic [N_PORTS-1:0]           ingress_last;
  logic [N_PORTS*IDX_WIDTH-1:0] ingress_dst;
  logic [N_PORTS-1:0]           ingress_ready;
  logic                         egress_valid;
  logic                         egress_last;
  logic                         egress_ready;

  modport master (
    input  ingress_valid, ingress_last, ingress_dst, egress_ready,
    output ingress_ready, egress_valid, egress_last
  );

  modport slave (
    output ingress_valid, ingress_last, ingress_dst, egress_ready,
    input  ingress_ready, egress_valid, egress_last
  );
endinterface

// File: rtl/wrr_egress_arbiter.sv
// Per-egress packet arbiter: packet-atomic weighted round-robin over ingress ports,
// with a watchdog that abandons a grant whose ingress goes silent mid-packet.
//
// state | meaning
// IDLE  | no grant; searching requests from rr_ptr upward
// SEND  | packet from ingress sel forwarded until its last beat or watchdog expiry
module wrr_egress_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int IDX_WIDTH      = $clog2(N_PORTS),
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  wrr_egress_arbiter_if.master            bus,
  input  logic [IDX_WIDTH-1:0]            egress_port_id,
  input  logic [N_PORTS*WEIGHT_WIDTH-1:0] cfg_weights,
  input  logic                            cfg_load,
  output logic [IDX_WIDTH-1:0]            selected_ingress,
  output logic [N_PORTS-1:0]              grant,
  output logic                            busy,
  output logic                            timeout_pulse
);

  localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    sel_q, sel_d;
  logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0]      grant_q, grant_d;
  logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                    timeout_pulse_q, timeout_pulse_d;
  logic [WEIGHT_WIDTH-1:0] weight_q [N_PORTS];
  logic [WEIGHT_WIDTH-1:0] weight_d [N_PORTS];
  logic [WEIGHT_WIDTH-1:0] credit_q [N_PORTS];
  logic [WEIGHT_WIDTH-1:0] credit_d [N_PORTS];

  logic [N_PORTS-1:0]      req;
  logic                    hit;
  logic [IDX_WIDTH-1:0]    winner;
  logic [IDX_WIDTH-1:0]    cand;
  logic                    sel_valid;
  logic                    sel_last;
  logic [WEIGHT_WIDTH-1:0] credit_dec;

  function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req[i] = bus.ingress_valid[i] &&
               (bus.ingress_dst[i*IDX_WIDTH +: IDX_WIDTH] == egress_port_id);
    end
  end

  // Walk downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    hit    = 1'b0;
    winner = rr_ptr_q;
    cand   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      cand = rr_ptr_q + IDX_WIDTH'(k);
      if (req[cand]) begin
        hit    = 1'b1;
        winner = cand;
      end
    end
  end

  assign sel_valid  = bus.ingress_valid[sel_q];
  assign sel_last   = bus.ingress_last[sel_q];
  assign credit_dec = credit_q[sel_q] - WEIGHT_WIDTH'(1);

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    stall_cnt_d     = stall_cnt_q;
    timeout_pulse_d = 1'b0;
    weight_d        = weight_q;
    credit_d        = credit_q;

    if (cfg_load) begin
      for (int i = 0; i < N_PORTS; i++) begin
        weight_d[i] = cfg_weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        if (state_q == IDLE) credit_d[i] = eff_weight(weight_d[i]);
      end
    end

    unique case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (hit) begin
          state_d = SEND;
          sel_d   = winner;
          grant_d = N_PORTS'(1) << winner;
        end
      end
      SEND: begin
        if (sel_valid) begin
          stall_cnt_d = '0;
          if (bus.egress_ready && sel_last) begin
            if (credit_dec == '0) begin
              credit_d[sel_q] = eff_weight(weight_d[sel_q]);
              rr_ptr_d        = sel_q + IDX_WIDTH'(1);
            end else begin
              credit_d[sel_q] = credit_dec;
              rr_ptr_d        = sel_q;
            end
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_pulse_d = 1'b1;
          credit_d[sel_q] = eff_weight(weight_d[sel_q]);
          rr_ptr_d        = sel_q + IDX_WIDTH'(1);
          stall_cnt_d     = '0;
          state_d         = IDLE;
          grant_d         = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      stall_cnt_q     <= '0;
      timeout_pulse_q <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        weight_q[i] <= WEIGHT_WIDTH'(1);
        credit_q[i] <= WEIGHT_WIDTH'(1);
      end
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      stall_cnt_q     <= stall_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
      weight_q        <= weight_d;
      credit_q        <= credit_d;
    end
  end

  assign busy              = (state_q == SEND);
  assign grant             = grant_q;
  assign selected_ingress  = sel_q;
  assign timeout_pulse     = timeout_pulse_q;
  assign bus.egress_valid  = busy && sel_valid;
  assign bus.egress_last   = busy && sel_last;
  assign bus.ingress_ready = (busy && bus.egress_ready) ? grant_q : '0;

endmodule

// File: tb/tb_wrr_egress_arbiter.sv
// Bench for wrr_egress_arbiter: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a packet-level reference model of the arbitration rules.
module tb_wrr_egress_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int WW = 4;
  localparam int TO = 16;

  typedef int iq_t[$];

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [IW-1:0]   egress_port_id = 2'd2;
  logic [N*WW-1:0] cfg_weights = '0;
  logic            cfg_load = 1'b0;
  logic [IW-1:0]   selected_ingress;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_pulse;

  wrr_egress_arbiter_if #(.N_PORTS(N), .IDX_WIDTH(IW)) bus ();

  wrr_egress_arbiter #(.N_PORTS(N), .IDX_WIDTH(IW), .WEIGHT_WIDTH(WW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .egress_port_id(egress_port_id),
    .cfg_weights(cfg_weights), .cfg_load(cfg_load), .selected_ingress(selected_ingress),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: who holds the egress, search start, credits and weights
  bit m_busy, m_tp;
  int m_sel, m_ptr, m_stall;
  int m_w[N];
  int m_cr[N];

  // packet sources, one per ingress
  int src_npk[N], src_len[N], src_beat[N], src_dst[N];
  bit src_drop[N];
  bit rnd_mode = 1'b0;
  int gap_pct = 0;

  iq_t order_q;
  int  tp_cyc[$];
  int  last_xfer_cyc[N];
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit req(input int p);
    return bus.ingress_valid[p] && (bus.ingress_dst[p*IW +: IW] == egress_port_id);
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_npk[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tp = 0; m_sel = 0; m_ptr = 0; m_stall = 0;
    for (int i = 0; i < N; i++) begin m_w[i] = 1; m_cr[i] = 1; end
  endtask

  task automatic src_set(input int i, input int npk, input int len, input bit drop);
    src_npk[i] = npk; src_len[i] = len; src_beat[i] = 0; src_dst[i] = 2; src_drop[i] = drop;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bit v;
      v = (src_npk[i] > 0) && !(src_drop[i] && src_beat[i] >= 1);
      if (rnd_mode && ($urandom_range(99) < gap_pct)) v = 1'b0;
      bus.ingress_valid[i] = v;
      bus.ingress_last[i]  = (src_beat[i] == src_len[i] - 1);
      bus.ingress_dst[i*IW +: IW] = IW'(src_dst[i]);
    end
  endtask

  // Called ~1 time unit after a rising edge with inputs already driven.
  task automatic step();
    logic [N-1:0] eg, er;
    bit ev, xfer, nbusy, ntp;
    int nsel, nptr, nstall, xs;
    int nw[N];
    int ncr[N];
    #1;
    eg = m_busy ? (N'(1) << m_sel) : '0;
    er = (m_busy && bus.egress_ready) ? eg : '0;
    ev = m_busy && bus.ingress_valid[m_sel];
    check("grant", grant, eg);
    check("busy", busy, m_busy);
    check("selected_ingress", selected_ingress, m_sel);
    check("egress_valid", bus.egress_valid, ev);
    check("ingress_ready", bus.ingress_ready, er);
    check("timeout_pulse", timeout_pulse, m_tp);
    if (ev) check("egress_last", bus.egress_last, src_beat[m_sel] == src_len[m_sel] - 1);
    if (grant != '0 && prev_grant == '0) order_q.push_back(onehot_idx(grant));
    prev_grant = grant;
    if (timeout_pulse) tp_cyc.push_back(cyc);

    nbusy = m_busy; ntp = 0; nsel = m_sel; nptr = m_ptr; nstall = m_stall;
    nw = m_w; ncr = m_cr;
    xfer = ev && bus.egress_ready;
    xs = m_sel;
    if (cfg_load) begin
      for (int i = 0; i < N; i++) begin
        nw[i] = int'(cfg_weights[i*WW +: WW]);
        if (!m_busy) ncr[i] = eff(nw[i]);
      end
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (req((m_ptr + k) % N)) begin
          nbusy = 1; nsel = (m_ptr + k) % N; break;
        end
      end
    end else if (bus.ingress_valid[m_sel]) begin
      nstall = 0;
      if (bus.egress_ready && bus.ingress_last[m_sel]) begin
        ncr[m_sel] = m_cr[m_sel] - 1;
        if (ncr[m_sel] == 0) begin
          ncr[m_sel] = eff(nw[m_sel]);
          nptr = (m_sel + 1) % N;
        end else begin
          nptr = m_sel;
        end
        nbusy = 0;
      end
    end else if (m_stall == TO - 1) begin
      ntp = 1; ncr[m_sel] = eff(nw[m_sel]); nptr = (m_sel + 1) % N; nbusy = 0; nstall = 0;
    end else begin
      nstall = m_stall + 1;
    end

    @(posedge clk);
    cyc++;
    m_busy = nbusy; m_tp = ntp; m_sel = nsel; m_ptr = nptr; m_stall = nstall;
    m_w = nw; m_cr = ncr;
    if (xfer) begin
      src_beat[xs]++;
      last_xfer_cyc[xs] = cyc;
      if (src_beat[xs] == src_len[xs]) begin
        src_beat[xs] = 0;
        src_npk[xs]--;
        if (rnd_mode) begin
          src_len[xs] = 1 + int'($urandom_range(3));
          src_dst[xs] = int'($urandom_range(3));
        end
      end
    end
    #1;
    if (rnd_mode) begin
      for (int i = 0; i < N; i++)
        if (!(m_busy && m_sel == i) && src_beat[i] == 0 && $urandom_range(9) == 0)
          src_dst[i] = int'($urandom_range(3));
      bus.egress_ready = ($urandom_range(9) < 7);
      cfg_load = ($urandom_range(49) == 0);
      cfg_weights = (N*WW)'($urandom);
    end
    drive_inputs();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    drive_inputs();
    while ((pending() || m_busy) && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, n < max_cyc, 1);
  endtask

  task automatic check_order(input string tag, input iq_t e);
    check({tag, "_count"}, order_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < order_q.size()) check(tag, order_q[i], e[i]);
  endtask

  initial begin
    iq_t e;
    model_reset();
    for (int i = 0; i < N; i++) src_set(i, 0, 1, 0);
    bus.egress_ready = 1'b1;
    drive_inputs();
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", selected_ingress, 0);
    check("rst_egress_valid", bus.egress_valid, 0);
    check("rst_ingress_ready", bus.ingress_ready, 0);
    check("rst_timeout", timeout_pulse, 0);
    reset = 1'b0;

    // equal weights, all ports sending 2-beat packets
    for (int i = 0; i < N; i++) src_set(i, 2, 2, 0);
    order_q.delete();
    drain("t1_drain", 200);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("t1_order", e);

    // port 0 weight 2 loaded while idle
    cfg_weights = 16'h1112;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    src_set(0, 4, 1, 0); src_set(1, 2, 2, 0); src_set(2, 2, 3, 0); src_set(3, 2, 1, 0);
    order_q.delete();
    drain("t2_drain", 300);
    e = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    check_order("t2_order", e);

    // lone port 3, pointer wraps to 0, then 1 beats 2
    order_q.delete();
    src_set(3, 1, 2, 0);
    drain("t3a_drain", 50);
    src_set(1, 1, 1, 0); src_set(2, 1, 1, 0);
    drain("t3b_drain", 50);
    e = '{3, 1, 2};
    check_order("t3_order", e);

    // long backpressure must not trip the watchdog
    order_q.delete();
    tp_cyc.delete();
    src_set(1, 1, 3, 0);
    drive_inputs();
    for (int n = 0; n < 10 && !m_busy; n++) step();
    check("t4_granted", busy, 1);
    bus.egress_ready = 1'b0;
    drive_inputs();
    repeat (2000) step();
    check("t4_no_timeout", tp_cyc.size(), 0);
    bus.egress_ready = 1'b1;
    drain("t4_drain", 20);
    e = '{1};
    check_order("t4_order", e);

    // port 2 goes silent after one beat
    order_q.delete();
    tp_cyc.delete();
    src_set(2, 1, 4, 1);
    drive_inputs();
    for (int n = 0; n < 60 && tp_cyc.size() == 0; n++) step();
    check("t5_timeout_count", tp_cyc.size(), 1);
    if (tp_cyc.size() > 0) check("t5_timeout_cycle", tp_cyc[0], last_xfer_cyc[2] + TO);
    check("t5_grant_cleared", grant, 0);
    src_set(2, 0, 1, 0);
    src_set(1, 1, 1, 0); src_set(3, 1, 1, 0);
    drain("t5_drain", 50);
    e = '{2, 3, 1};
    check_order("t5_order", e);

    // asynchronous reset in the middle of a packet
    order_q.delete();
    for (int i = 0; i < N; i++) src_set(i, 2, 3, 0);
    drive_inputs();
    for (int n = 0; n < 20 && !(m_busy && src_beat[m_sel] >= 1); n++) step();
    check("t6_midpacket", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_grant", grant, 0);
    check("t6_async_valid", bus.egress_valid, 0);
    check("t6_async_ready", bus.ingress_ready, 0);
    model_reset();
    prev_grant = '0;
    for (int i = 0; i < N; i++) src_set(i, 2, 3, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    order_q.delete();
    drain("t6_drain", 200);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("t6_order", e);

    // randomized traffic, gaps, backpressure and live weight changes
    rnd_mode = 1'b1;
    gap_pct = 15;
    for (int i = 0; i < N; i++) begin
      src_set(i, 1000, 1 + int'($urandom_range(3)), 0);
      src_dst[i] = int'($urandom_range(3));
    end
    drive_inputs();
    repeat (4000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
